// File: rtl/edge_window_sequencer.sv
// edge_window_sequencer
//
// Feeds a raster-order pixel stream into the 3x3 edge-detection stage. Two
// line buffers and a 3x3 window are maintained. For every complete window
// the nine pixels are loaded through the one-hot command bus. The stage is
// then told to convolve, and its result is returned on a valid/ready stream.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   pix_in[_valid/_sof] input pixel stream; sof marks pixel (0,0)
//   pix_in_ready        pixel accepted this cycle when valid & ready
//   edge_data_in        data driven to the edge stage
//   edge_command        registered one-hot command to the edge stage
//   edge_data_out       edge stage result bus
//   res_out/res_eol     convolution result, last-of-line flag
//   res_valid/res_ready result stream handshake
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a pixel; non-windowed pixels are absorbed here
// LOAD  | nine cycles, one window pixel per cycle, command 1<<(k-1)
// CONV  | command 0x0200, result captured at end of cycle
// OUT   | res_valid high until res_ready

module edge_window_sequencer #(
  parameter int IMG_WIDTH = 64,
  parameter int PIX_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_in_valid,
  input  logic             pix_in_sof,
  output logic             pix_in_ready,
  output logic [PIX_W-1:0] edge_data_in,
  output logic [15:0]      edge_command,
  input  logic [PIX_W-1:0] edge_data_out,
  output logic [PIX_W-1:0] res_out,
  output logic             res_eol,
  output logic             res_valid,
  input  logic             res_ready
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CONV, OUT} state_t;

  state_t           state, state_nxt;
  logic [3:0]       ld_cnt, ld_cnt_nxt;
  logic [3:0]       nxt_idx;
  logic [15:0]      cmd_nxt;
  logic [PIX_W-1:0] data_nxt;

  logic [COL_W-1:0] col, col_eff;
  logic             row_ge1, row_ge2, row_ge1_eff, row_ge2_eff;
  logic             accept, win_ok, at_eol, pend_eol;

  logic [PIX_W-1:0] lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] lb2 [IMG_WIDTH];
  logic [PIX_W-1:0] win [3][3];
  logic [PIX_W-1:0] win_flat [9];

  assign pix_in_ready = (state == IDLE) & ~reset;
  assign res_valid    = (state == OUT);
  assign accept       = pix_in_valid & pix_in_ready;

  // An accepted sof restarts the raster position before this pixel uses it.
  assign col_eff     = pix_in_sof ? '0 : col;
  assign row_ge1_eff = pix_in_sof ? 1'b0 : row_ge1;
  assign row_ge2_eff = pix_in_sof ? 1'b0 : row_ge2;
  assign win_ok      = row_ge2_eff & (col_eff >= COL_W'(2));
  assign at_eol      = (col_eff == COL_LAST);

  always_comb begin
    for (int i = 0; i < 9; i++) win_flat[i] = win[i / 3][i % 3];
  end

  // ld_cnt counts the remaining LOAD cycles down to zero; the pixel for the
  // following cycle is therefore 9 - ld_cnt.
  assign nxt_idx = 4'd9 - ld_cnt;

  always_comb begin
    state_nxt  = state;
    ld_cnt_nxt = ld_cnt;
    cmd_nxt    = 16'h0000;
    data_nxt   = '0;
    case (state)
      IDLE: begin
        if (accept && win_ok) begin
          state_nxt  = LOAD;
          ld_cnt_nxt = 4'd8;
          cmd_nxt    = 16'h0001;
          // The window shifts on this same edge, so top-left of the new
          // window is the current top-middle.
          data_nxt   = win[0][1];
        end
      end
      LOAD: begin
        if (ld_cnt == 4'd0) begin
          state_nxt = CONV;
          cmd_nxt   = 16'h0200;
        end else begin
          ld_cnt_nxt = ld_cnt - 4'd1;
          cmd_nxt    = 16'h0001 << nxt_idx;
          data_nxt   = win_flat[nxt_idx];
        end
      end
      CONV: state_nxt = OUT;
      OUT: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ld_cnt       <= 4'd0;
      edge_command <= 16'h0000;
      edge_data_in <= '0;
      res_out      <= '0;
      res_eol      <= 1'b0;
      pend_eol     <= 1'b0;
    end else begin
      state        <= state_nxt;
      ld_cnt       <= ld_cnt_nxt;
      edge_command <= cmd_nxt;
      edge_data_in <= data_nxt;
      if (accept) pend_eol <= at_eol;
      if (state == CONV) begin
        res_out <= edge_data_out;
        res_eol <= pend_eol;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col     <= '0;
      row_ge1 <= 1'b0;
      row_ge2 <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb2[col_eff];
      win[1][2] <= lb1[col_eff];
      win[2][2] <= pix_in;
      if (at_eol) begin
        col     <= '0;
        row_ge1 <= 1'b1;
        row_ge2 <= row_ge1_eff;
      end else begin
        col     <= col_eff + COL_W'(1);
        row_ge1 <= row_ge1_eff;
        row_ge2 <= row_ge2_eff;
      end
    end
  end

  // Line buffers hold no state worth clearing; validity comes from row_ge2.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col_eff] <= lb1[col_eff];
      lb1[col_eff] <= pix_in;
    end
  end

endmodule

// File: tb/tb_edge_window_sequencer.sv
module tb_edge_window_sequencer;
  localparam int W  = 8;
  localparam int NR = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pix_in;
  logic        pix_in_valid, pix_in_sof, pix_in_ready;
  logic [15:0] edge_data_in, edge_command, edge_data_out, res_out;
  logic        res_eol, res_valid, res_ready;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 1;

  typedef struct packed {logic [15:0] v; logic e;} res_t;
  res_t got_q[$];
  res_t exp_q[$];

  logic [15:0] fr [NR][W];

  always #5 clk = ~clk;

  edge_window_sequencer #(.IMG_WIDTH(W), .PIX_W(16)) dut (
    .clk(clk), .reset(reset),
    .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_sof(pix_in_sof),
    .pix_in_ready(pix_in_ready),
    .edge_data_in(edge_data_in), .edge_command(edge_command),
    .edge_data_out(edge_data_out),
    .res_out(res_out), .res_eol(res_eol), .res_valid(res_valid),
    .res_ready(res_ready)
  );

  // Kernel of the edge stage model: center 8, middle-left 0, others -1.
  function automatic int kern(input int i);
    if (i == 4) return 8;
    if (i == 3) return 0;
    return -1;
  endfunction

  // Edge stage model: latch per one-hot bit, present the sum during 0x0200.
  logic [15:0] es_reg [9];
  int es_acc;
  always @(posedge clk)
    for (int k = 0; k < 9; k++) if (edge_command[k]) es_reg[k] <= edge_data_in;
  always_comb begin
    es_acc = 0;
    for (int k = 0; k < 9; k++) es_acc += kern(k) * int'($signed(es_reg[k]));
    edge_data_out = (edge_command == 16'h0200) ? es_acc[15:0] : 16'hDEAD;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: result for the window whose bottom-right pixel is (r,c).
  function automatic logic [15:0] ref_conv(input int r, input int c);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += kern(i * 3 + j) * int'($signed(fr[r - 2 + i][c - 2 + j]));
    return s[15:0];
  endfunction

  task automatic add_expected(input int nrows, input int last_len);
    int len;
    for (int r = 2; r < nrows; r++) begin
      len = (r == nrows - 1) ? last_len : W;
      for (int c = 2; c < len; c++) exp_q.push_back({ref_conv(r, c), (c == W - 1)});
    end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < W; c++) fr[r][c] = 16'($urandom);
  endtask

  // Collector and hold-stability monitor.
  logic pv = 1'b0, pr = 1'b0, prst = 1'b1, pe = 1'b0;
  logic [15:0] po = '0;
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) got_q.push_back({res_out, res_eol});
    if (pv && !pr && !prst) begin
      chk("hold_valid", res_valid, 1);
      chk("hold_out", res_out, po);
      chk("hold_eol", res_eol, pe);
    end
    pv = res_valid; pr = res_ready; prst = reset; po = res_out; pe = res_eol;
  end

  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1) res_ready = 1'b1;
      else if (rdy_mode == 2) res_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Called and returns at posedge+1.
  task automatic send_pix(input logic [15:0] p, input logic sof, input bit gaps);
    int n;
    if (gaps && $urandom_range(0, 3) == 0) begin
      pix_in_valid = 1'b0;
      pix_in_sof   = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    end
    pix_in = p; pix_in_valid = 1'b1; pix_in_sof = sof; n = 0;
    @(negedge clk);
    while (!pix_in_ready && n < 200) begin n++; @(negedge clk); end
    if (!pix_in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk); #1;
    pix_in_valid = 1'b0; pix_in_sof = 1'b0;
  endtask

  task automatic run_frame(input int nrows, input int last_len, input bit gaps);
    int len;
    for (int r = 0; r < nrows; r++) begin
      len = (r == nrows - 1) ? last_len : W;
      for (int c = 0; c < len; c++) send_pix(fr[r][c], (r == 0 && c == 0), gaps);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while (!pix_in_ready && n < 400) begin n++; @(negedge clk); end
    if (!pix_in_ready) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk); #1;
  endtask

  task automatic compare_q(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({name, "_val"}, got_q[i].v, exp_q[i].v);
      chk({name, "_eol"}, got_q[i].e, exp_q[i].e);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    int          fill;
    int          ir, ic;
    logic [15:0] ival;
    int          cr, cc;
    logic [15:0] exp;
    logic        exp_eol;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int idx;
    tbl[0] = '{5, -1, 0, 16'h0000, 1, 1, 16'h0005, 1'b0};
    tbl[1] = '{5, -1, 0, 16'h0000, 1, 6, 16'h0005, 1'b1};
    tbl[2] = '{5, -1, 0, 16'h0000, 2, 6, 16'h0005, 1'b1};
    tbl[3] = '{5, -1, 0, 16'h0000, 2, 3, 16'h0005, 1'b0};
    tbl[4] = '{0,  1, 1, 16'd100,  1, 1, 16'h0320, 1'b0};
    tbl[5] = '{0,  1, 1, 16'd100,  2, 2, 16'hFF9C, 1'b0};
    tbl[6] = '{0,  1, 1, 16'd100,  2, 1, 16'hFF9C, 1'b0};
    tbl[7] = '{0,  1, 1, 16'd100,  1, 2, 16'h0000, 1'b0};
    tbl[8] = '{0,  1, 1, 16'd100,  2, 4, 16'h0000, 1'b0};
    tbl[9] = '{0,  2, 4, 16'h3000, 2, 4, 16'h8000, 1'b0};

    reset = 1'b1; pix_in = '0; pix_in_valid = 1'b0; pix_in_sof = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", pix_in_ready, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_cmd", edge_command, 0);
    chk("rst_data", edge_data_in, 0);
    chk("rst_res", res_out, 0);
    chk("rst_eol", res_eol, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", pix_in_ready, 1);
    @(posedge clk); #1;

    // Table-driven frames.
    for (int t = 0; t < 10; t++) begin
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < W; c++) fr[r][c] = 16'(tbl[t].fill);
      if (tbl[t].ir >= 0) fr[tbl[t].ir][tbl[t].ic] = tbl[t].ival;
      got_q.delete();
      run_frame(NR, W, 1'b0);
      drain();
      chk("tbl_count", got_q.size(), 12);
      idx = (tbl[t].cr - 1) * (W - 2) + (tbl[t].cc - 1);
      if (idx < got_q.size()) begin
        chk("tbl_val", got_q[idx].v, tbl[t].exp);
        chk("tbl_eol", got_q[idx].e, tbl[t].exp_eol);
      end else begin
        checks++; errors++;
        $display("FAIL tbl_missing: got %0d results expected index %0d", got_q.size(), idx);
      end
      got_q.delete();
    end

    // Random frames with random gaps and backpressure.
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) begin
      fill_rand();
      add_expected(NR, W);
      run_frame(NR, W, 1'b1);
      drain();
      compare_q("rand");
    end
    rdy_mode = 1;
    drain();

    // Command trace and backpressure for one window.
    rdy_mode = 0;
    res_ready = 1'b0;
    fill_rand();
    run_frame(3, 2, 1'b0);
    pix_in = fr[2][2]; pix_in_valid = 1'b1; pix_in_sof = 1'b0;
    @(negedge clk);
    chk("trace_ready", pix_in_ready, 1);
    @(posedge clk); #1 pix_in_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("trace_cmd", edge_command, 32'(1) << (k - 1));
      chk("trace_data", edge_data_in, fr[(k - 1) / 3][(k - 1) % 3]);
    end
    @(negedge clk);
    chk("trace_conv_cmd", edge_command, 16'h0200);
    chk("trace_conv_valid", res_valid, 0);
    @(negedge clk);
    chk("trace_out_valid", res_valid, 1);
    chk("trace_out_cmd", edge_command, 0);
    chk("trace_out_res", res_out, ref_conv(2, 2));
    chk("trace_out_eol", res_eol, 0);
    pix_in = fr[2][3]; pix_in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", pix_in_ready, 0);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", res_valid, 1);
    chk("bp_hs_ready", pix_in_ready, 0);
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    chk("bp_resume_ready", pix_in_ready, 1);
    @(posedge clk); #1 pix_in_valid = 1'b0;
    rdy_mode = 1;
    drain();
    exp_q.push_back({ref_conv(2, 2), 1'b0});
    exp_q.push_back({ref_conv(2, 3), 1'b0});
    compare_q("bp");

    // Reset during LOAD cycle 4.
    fill_rand();
    run_frame(3, 2, 1'b0);
    got_q.delete();
    pix_in = fr[2][2]; pix_in_valid = 1'b1; pix_in_sof = 1'b0;
    @(negedge clk);
    chk("rl_ready", pix_in_ready, 1);
    @(posedge clk); #1 pix_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rl_cmd4", edge_command, 16'h0008);
    reset = 1'b1;
    @(negedge clk);
    chk("rl_cmd_after", edge_command, 0);
    chk("rl_valid_after", res_valid, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rl_ready_release", pix_in_ready, 1);
    chk("rl_no_result", got_q.size(), 0);
    @(posedge clk); #1;
    fill_rand();
    add_expected(NR, W);
    run_frame(NR, W, 1'b1);
    drain();
    compare_q("rl_frame");

    // sof in mid-line at column 5 of row 2.
    rdy_mode = 2;
    fill_rand();
    add_expected(3, 5);
    run_frame(3, 5, 1'b1);
    fill_rand();
    add_expected(NR, W);
    run_frame(NR, W, 1'b1);
    drain();
    compare_q("sof_mid");
    rdy_mode = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
